vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//  Shares the single VRAM SDRAM controller between three requesters: refresh,
//  display scanout fetch and host (GPMC) writes. Sits between main's scanout
//  logic and the host bridge on one side, and the SDRAM command controller on
//  the other. Buffers host writes in a small FIFO and ages them so that display
//  priority cannot starve them.
// PARAMETERS
//  ADDR_W      24  VRAM word address width (bank+row+col)
//  FIFO_DEPTH  2   host write FIFO entries (power of 2, >=2)
//  AGE_MAX     63  cycles a pending host write waits before promotion over disp
// PORTS
//  pixel_clk        in   1       sole clock
//  reset            in   1       async, active-high
//  refresh_req      in   1       level; refresh due
//  refresh_grant    out  1       1-cycle pulse, refresh cmd accepted by mem
//  disp_req         in   1       level; scanout fetch wanted
//  disp_urgent      in   1       level; line buffer near underrun
//  disp_addr        in   ADDR_W  fetch address, sampled at grant decision
//  disp_grant       out  1       1-cycle pulse, disp read accepted by mem
//  disp_done        out  1       1-cycle pulse, disp read completed
//  host_vram_cs     in   1       1-cycle write strobe from host bridge
//  host_vram_addr   in   ADDR_W  write address
//  host_vram_data   in   16      write data
//  host_write_avail out  1       FIFO not full
//  host_vram_done   out  1       1-cycle pulse, host write completed in VRAM
//  host_overflow    out  1       sticky: strobe arrived while FIFO full
//  mem_valid        out  1       command valid to SDRAM controller
//  mem_cmd          out  2       00 none, 01 read, 10 write, 11 refresh
//  mem_addr         out  ADDR_W  command address
//  mem_wdata        out  16      write data
//  mem_ready        in   1       controller accepts command when valid&ready
//  mem_done         in   1       1-cycle pulse, accepted command finished
// BEHAVIOUR
//  Reset (async): FSM=IDLE, FIFO empty, age=0; mem_valid=0, mem_cmd=00,
//   mem_addr=0, mem_wdata=0, all pulses 0, host_overflow=0, host_write_avail=1.
//   Reset mid-command aborts silently; no done pulse is generated.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE. One command is outstanding at a time.
//   IDLE: if any request is pending, pick a winner, register cmd/addr/wdata
//    and owner, then go to ISSUE. mem_valid rises the cycle after the request
//    is seen (1-cycle latency).
//   ISSUE: hold mem_valid and all command fields stable until mem_ready. On
//    valid&ready, drop mem_valid, pulse the owner grant (host: pop FIFO,
//    age<=0), then go to WAIT.
//   WAIT: on mem_done, pulse the owner done (disp_done or host_vram_done;
//    refresh has none), then go to IDLE. A mem_done seen in the ISSUE or IDLE
//    state is ignored.
//   The FSM spends a minimum of 1 cycle in IDLE between commands.
//  Priority (evaluated in IDLE only), highest first: refresh_req; disp_urgent
//   with disp_req; host aged (FIFO non-empty && age==AGE_MAX); disp_req; host
//   FIFO non-empty.
//  FIFO: push on host_vram_cs && !full. A strobe while full is dropped and sets
//   host_overflow. A pop takes effect in the same cycle as the host acceptance.
//   A push and pop in the same cycle are both honoured; full status is
//   evaluated before the pop. host_write_avail = !full, combinational from the
//   registered count. Pointers wrap modulo FIFO_DEPTH. The head entry is
//   written in order; no merging.
//  Age: increments each cycle the FIFO is non-empty and the host is not being
//   granted. It saturates at AGE_MAX and clears on host acceptance or when the
//   FIFO is empty.
//  disp_addr is sampled only in IDLE at the winning decision. It may change
//   during the cycles that follow.
// TESTING
//  1 Reset: assert reset mid-WAIT -> mem_valid=0 same edge, avail=1, no
//    done pulse; after release, idle with no commands.
//  2 Contention: refresh_req, disp_req and FIFO entry all at once with
//    mem_ready=1 and mem_done 3 cycles later -> order is refresh, disp, host.
//    disp_done and host_vram_done each pulse exactly once.
//  3 Starvation: disp_req held high, one host write at 0x000123/0xBEEF ->
//    host write issued within AGE_MAX+1 cycles, plus the in-flight disp
//    command. mem_cmd=10, mem_wdata=0xBEEF.
//  4 FIFO full: 3 strobes with mem_ready=0 -> avail=0 after 2nd strobe, 3rd
//    dropped, host_overflow=1. After drain, exactly 2 writes issue, in order.
//  5 Backpressure: mem_ready low 5 cycles during ISSUE -> mem_cmd/addr/wdata
//    stable for all 5 cycles, grant pulses only on the accept cycle.
//  6 Urgent: disp_urgent=1 with host aged -> disp wins; host is next.

Source files
------------

// File: rtl/vram_arbiter.sv
// Arbitrates the single SDRAM command port between refresh, scanout reads and
// buffered host writes; one command in flight, aged host writes beat plain scanout.
module vram_arbiter #(
   parameter int ADDR_W     = 24,
   parameter int FIFO_DEPTH = 2,
   parameter int AGE_MAX    = 63
) (
   input  logic              pixel_clk,
   input  logic              reset,
   input  logic              refresh_req,
   output logic              refresh_grant,
   input  logic              disp_req,
   input  logic              disp_urgent,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_grant,
   output logic              disp_done,
   input  logic              host_vram_cs,
   input  logic [ADDR_W-1:0] host_vram_addr,
   input  logic [15:0]       host_vram_data,
   output logic              host_write_avail,
   output logic              host_vram_done,
   output logic              host_overflow,
   output logic              mem_valid,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_done
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int AW = $clog2(AGE_MAX + 1);

   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_WR   = 2'b10;
   localparam logic [1:0] CMD_REF  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic [1:0] {OWN_REF, OWN_DISP, OWN_HOST} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic [1:0]          cmd_q, cmd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;

   logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [15:0]         fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0]       wptr_q, rptr_q;
   logic [CW-1:0]       count_q, count_d;
   logic [AW-1:0]       age_q, age_d;
   logic                ovf_q;

   logic fifo_full, fifo_empty, accept, host_acc, push, host_aged;
   logic pick_ref, pick_disp, pick_host;

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign accept     = (state_q == S_ISSUE) && mem_ready;
   assign host_acc   = accept && (owner_q == OWN_HOST);
   // Full is judged on the registered count, so a pop this cycle does not free a slot for a strobe.
   assign push       = host_vram_cs && !fifo_full;
   assign host_aged  = !fifo_empty && (age_q == AW'(AGE_MAX));

   always_comb begin
      pick_ref  = 1'b0;
      pick_disp = 1'b0;
      pick_host = 1'b0;
      if (refresh_req)                    pick_ref  = 1'b1;
      else if (disp_urgent && disp_req)   pick_disp = 1'b1;
      else if (host_aged)                 pick_host = 1'b1;
      else if (disp_req)                  pick_disp = 1'b1;
      else if (!fifo_empty)               pick_host = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (pick_ref) begin
               owner_d = OWN_REF;
               cmd_d   = CMD_REF;
               addr_d  = '0;
               wdata_d = '0;
               state_d = S_ISSUE;
            end else if (pick_disp) begin
               owner_d = OWN_DISP;
               cmd_d   = CMD_RD;
               addr_d  = disp_addr;
               wdata_d = '0;
               state_d = S_ISSUE;
            end else if (pick_host) begin
               owner_d = OWN_HOST;
               cmd_d   = CMD_WR;
               addr_d  = fifo_addr_q[rptr_q];
               wdata_d = fifo_data_q[rptr_q];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_ready) begin
               cmd_d   = CMD_NONE;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= OWN_REF;
         cmd_q   <= CMD_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, host_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Age keeps counting while a host write sits in ISSUE under backpressure.
   always_comb begin
      age_d = age_q;
      if (host_acc || fifo_empty)       age_d = '0;
      else if (age_q != AW'(AGE_MAX))   age_d = age_q + 1'b1;
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         age_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         age_q   <= age_d;
         if (push)     wptr_q <= wptr_q + 1'b1;
         if (host_acc) rptr_q <= rptr_q + 1'b1;
         if (host_vram_cs && fifo_full) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (push) begin
         fifo_addr_q[wptr_q] <= host_vram_addr;
         fifo_data_q[wptr_q] <= host_vram_data;
      end
   end

   assign mem_valid        = (state_q == S_ISSUE);
   assign mem_cmd          = cmd_q;
   assign mem_addr         = addr_q;
   assign mem_wdata        = wdata_q;
   assign refresh_grant    = accept && (owner_q == OWN_REF);
   assign disp_grant       = accept && (owner_q == OWN_DISP);
   assign disp_done        = (state_q == S_WAIT) && mem_done && (owner_q == OWN_DISP);
   assign host_vram_done   = (state_q == S_WAIT) && mem_done && (owner_q == OWN_HOST);
   assign host_write_avail = !fifo_full;
   assign host_overflow    = ovf_q;

endmodule
